// File: rtl/vmicro16_wb_arbiter_if.sv
// Wishbone bundle between the vmicro16 core masters, the arbiter and the shared SoC slave bus.
// The "slave" modport is the arbiter's view; the "master" modport is the surrounding cores and slave.
interface vmicro16_wb_arbiter_if #(
    parameter int MASTERS = 2
);
    logic [MASTERS-1:0]      m_cyc_i;
    logic [MASTERS-1:0]      m_stb_i;
    logic [MASTERS-1:0]      m_we_i;
    logic [16*MASTERS-1:0]   m_addr_i;
    logic [16*MASTERS-1:0]   m_data_i;
    logic [15:0]             m_data_o;
    logic [MASTERS-1:0]      m_ack_o;
    logic [MASTERS-1:0]      m_err_o;
    logic [MASTERS-1:0]      grant_o;
    logic                    s_cyc_o;
    logic                    s_stb_o;
    logic                    s_we_o;
    logic [15:0]             s_addr_o;
    logic [15:0]             s_data_o;
    logic [15:0]             s_data_i;
    logic                    s_ack_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
        output m_data_o, m_ack_o, m_err_o, grant_o,
               s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, s_data_i, s_ack_i,
        input  m_data_o, m_ack_o, m_err_o, grant_o,
               s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o
    );
endinterface

// File: rtl/vmicro16_wb_arbiter.sv
// Round-robin Wishbone arbiter: ownership is held for a whole cyc, one IDLE cycle between owners.
// Optional hung-slave watchdog enabled by defining VMICRO16_WB_ARB_TIMEOUT_EN.
module vmicro16_wb_arbiter #(
    parameter int MASTERS = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    vmicro16_wb_arbiter_if.slave      bus
);
    localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [MASTERS-1:0] r_grant;
    logic [MASTERS-1:0] w_grant_next;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      w_owner_next;
    logic [IW-1:0]      r_last;
    logic [IW-1:0]      w_last_next;

    logic               w_rr_found;
    logic [IW-1:0]      w_rr_idx;
    logic [IW-1:0]      w_cand;

    logic               w_own_cyc;
    logic               w_own_stb;
    logic               w_own_we;
    logic [15:0]        w_own_addr;
    logic [15:0]        w_own_data;
    logic               w_tmo;

    // Round-robin search upward from last+1 with wrap.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = r_last;
        w_cand     = r_last;
        for (int k = 1; k <= MASTERS; k++) begin
            w_cand = IW'((int'(r_last) + k) % MASTERS);
            if (!w_rr_found && bus.m_cyc_i[w_cand]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_cand;
            end else begin
                w_rr_found = w_rr_found;
            end
        end
    end

    // Owner's request signals, forced to zero while nobody owns the bus.
    always_comb begin
        w_own_cyc  = 1'b0;
        w_own_stb  = 1'b0;
        w_own_we   = 1'b0;
        w_own_addr = 16'h0000;
        w_own_data = 16'h0000;
        if (r_state == ST_OWNED) begin
            w_own_cyc  = bus.m_cyc_i[r_owner];
            w_own_stb  = bus.m_stb_i[r_owner];
            w_own_we   = bus.m_we_i[r_owner];
            w_own_addr = bus.m_addr_i[{r_owner, 4'b0000} +: 16];
            w_own_data = bus.m_data_i[{r_owner, 4'b0000} +: 16];
        end else begin
            w_own_cyc  = 1'b0;
        end
    end

    // Next-state and next-grant logic.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_owner_next = r_owner;
        w_last_next  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (w_rr_found) begin
                    w_state_next = ST_OWNED;
                    w_grant_next = {{(MASTERS-1){1'b0}}, 1'b1} << w_rr_idx;
                    w_owner_next = w_rr_idx;
                end else begin
                    w_grant_next = {MASTERS{1'b0}};
                end
            end
            ST_OWNED: begin
                if (!w_own_cyc) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = {MASTERS{1'b0}};
                    w_last_next  = r_owner;
                end else begin
                    w_state_next = ST_OWNED;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = {MASTERS{1'b0}};
            end
        endcase
    end

    // State, grant, owner and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_grant <= {MASTERS{1'b0}};
            r_owner <= {IW{1'b0}};
            r_last  <= IW'(MASTERS - 1);
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
            r_owner <= w_owner_next;
            r_last  <= w_last_next;
        end
    end

`ifdef VMICRO16_WB_ARB_TIMEOUT_EN
    logic [7:0] r_tmo_cnt;

    assign w_tmo = w_own_cyc && w_own_stb && (r_tmo_cnt == 8'(TIMEOUT));

    // Counts strobed cycles without an ack; any ack, idle strobe, release or expiry restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= 8'd0;
        end else if (w_own_cyc && w_own_stb && !bus.s_ack_i && !w_tmo) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
        end else begin
            r_tmo_cnt <= 8'd0;
        end
    end

    assign bus.m_err_o = r_grant & {MASTERS{w_tmo}};
`else
    assign w_tmo       = 1'b0;
    assign bus.m_err_o = {MASTERS{1'b0}};
`endif

    assign bus.grant_o  = r_grant;
    assign bus.s_cyc_o  = w_own_cyc;
    assign bus.s_stb_o  = w_own_stb & ~w_tmo;
    assign bus.s_we_o   = w_own_we;
    assign bus.s_addr_o = w_own_addr;
    assign bus.s_data_o = w_own_data;
    // Acks are steered only to the registered owner, so late acks after release go nowhere.
    assign bus.m_ack_o  = r_grant & {MASTERS{bus.s_ack_i | w_tmo}};
    assign bus.m_data_o = bus.s_data_i;

endmodule
